// File: rtl/rtc_bus_master.sv
// Bus initiator for the RTC unit's bus2ip slave port: turns 1..4-word read/write
// requests into one-cycle rd_ce/wr_ce beats and returns a single response.
module rtc_bus_master #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic         bus2ip_clk,
  input  logic         bus2ip_rst_n,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_wr_i,
  input  logic [31:0]  req_addr_i,
  input  logic [1:0]   req_len_i,
  input  logic [127:0] req_wdata_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_rdata_o,
  output logic [31:0]  bus2ip_addr_o,
  output logic [31:0]  bus2ip_data_o,
  output logic         bus2ip_rd_ce_o,
  output logic         bus2ip_wr_ce_o,
  input  logic [31:0]  ip2bus_data_i,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t         state_q, state_n;
  logic [31:0]    base_q, base_n;
  logic [1:0]     len_q, len_n;
  logic [1:0]     beat_q, beat_n;
  logic [2:0]     lat_q, lat_n;
  logic [127:0]   wdata_q, wdata_n;
  logic [127:0]   rdata_q, rdata_n;

  logic           rd_ce_n, wr_ce_n, rsp_valid_n;
  logic [31:0]    addr_n, data_n;
  logic [127:0]   rsp_rdata_n;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_n = state_q;
    base_n  = base_q;
    len_n   = len_q;
    beat_n  = beat_q;
    lat_n   = lat_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          base_n  = req_addr_i & 32'hFFFF_FFFC;
          len_n   = req_len_i;
          wdata_n = req_wdata_i;
          rdata_n = '0;
          beat_n  = 2'd0;
          state_n = req_wr_i ? WR_BEAT : RD_ISSUE;
        end
      end
      WR_BEAT: begin
        if (beat_q == len_q) state_n = RESP;
        else                 beat_n  = beat_q + 2'd1;
      end
      RD_ISSUE: begin
        lat_n   = LAT_LOAD;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        lat_n = lat_q - 3'd1;
        // Counter value 1 marks the cycle the slave's data is valid.
        if (lat_q == 3'd1) begin
          rdata_n[{beat_q, 5'b0} +: 32] = ip2bus_data_i;
          if (beat_q == len_q) begin
            state_n = RESP;
          end else begin
            beat_n  = beat_q + 2'd1;
            state_n = RD_ISSUE;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are precomputed from the next state so the registered strobes
    // line up with the cycle the state register enters that state.
    wr_ce_n     = (state_n == WR_BEAT);
    rd_ce_n     = (state_n == RD_ISSUE);
    addr_n      = (wr_ce_n || rd_ce_n) ? (base_n + {28'b0, beat_n, 2'b00}) : 32'h0;
    data_n      = wr_ce_n ? wdata_n[{beat_n, 5'b0} +: 32] : 32'h0;
    rsp_valid_n = (state_n == RESP);
    rsp_rdata_n = rsp_valid_n ? rdata_n : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state_q        <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      beat_q         <= '0;
      lat_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      bus2ip_rd_ce_o <= 1'b0;
      bus2ip_wr_ce_o <= 1'b0;
      bus2ip_addr_o  <= '0;
      bus2ip_data_o  <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
    end else begin
      state_q        <= state_n;
      base_q         <= base_n;
      len_q          <= len_n;
      beat_q         <= beat_n;
      lat_q          <= lat_n;
      wdata_q        <= wdata_n;
      rdata_q        <= rdata_n;
      bus2ip_rd_ce_o <= rd_ce_n;
      bus2ip_wr_ce_o <= wr_ce_n;
      bus2ip_addr_o  <= addr_n;
      bus2ip_data_o  <= data_n;
      rsp_valid_o    <= rsp_valid_n;
      rsp_rdata_o    <= rsp_rdata_n;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rtc_bus_master.sv
// Randomized bench for rtc_bus_master: a register-file slave with read latency,
// and a transaction-level model predicting every bus cycle and each response.
module tb_rtc_bus_master;

  localparam int RD_LAT = 2;

  logic         bus2ip_clk = 1'b0;
  logic         bus2ip_rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wr = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [1:0]   req_len = '0;
  logic [127:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_rdata;
  logic [31:0]  bus_addr, bus_data;
  logic         rd_ce, wr_ce;
  logic [31:0]  ip2bus_data = '0;
  logic         busy;

  int checks = 0;
  int failures = 0;

  rtc_bus_master #(.RD_LAT(RD_LAT)) dut (
    .bus2ip_clk     (bus2ip_clk),
    .bus2ip_rst_n   (bus2ip_rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_wr_i       (req_wr),
    .req_addr_i     (req_addr),
    .req_len_i      (req_len),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .bus2ip_addr_o  (bus_addr),
    .bus2ip_data_o  (bus_data),
    .bus2ip_rd_ce_o (rd_ce),
    .bus2ip_wr_ce_o (wr_ce),
    .ip2bus_data_i  (ip2bus_data),
    .busy_o         (busy)
  );

  always #5 bus2ip_clk = ~bus2ip_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave register file, written only by observed wr_ce beats.
  logic [31:0] slave_mem [logic [31:0]];
  logic        cur_rd, cur_wr;
  logic [31:0] cur_a, cur_d;
  logic        pipe_v [RD_LAT];
  logic [31:0] pipe_a [RD_LAT];

  initial for (int i = 0; i < RD_LAT; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = '0; end

  always @(negedge bus2ip_clk) begin
    cur_rd = rd_ce; cur_wr = wr_ce; cur_a = bus_addr; cur_d = bus_data;
  end

  always @(posedge bus2ip_clk) begin
    if (cur_wr) slave_mem[cur_a] = cur_d;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = cur_rd;
    pipe_a[0] = cur_a;
    #1;
    // Data is valid only in the sample cycle; junk elsewhere exposes mistimed capture.
    if (pipe_v[RD_LAT-1])
      ip2bus_data = slave_mem.exists(pipe_a[RD_LAT-1]) ? slave_mem[pipe_a[RD_LAT-1]] : 32'h0;
    else
      ip2bus_data = $urandom;
  end

  // Reference register file, updated per completed write transaction.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Runs one transaction starting at a negedge in IDLE; returns at the negedge
  // after the response handshake (or after a planted reset when abort_t > 0).
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [1:0] len,
                        input logic [127:0] wdata, input int hold, input bit queue_req,
                        input int abort_t);
    logic [31:0]  base, exp_a, exp_d;
    logic [127:0] exp_rd;
    logic         exp_rdce, exp_wrce;
    int           n, trsp, w, beat;
    base   = addr & 32'hFFFF_FFFC;
    n      = int'(len) + 1;
    exp_rd = '0;
    if (!wr) for (int i = 0; i < n; i++) exp_rd[32*i +: 32] = ref_rd(base + 32'(4*i));
    trsp = wr ? n + 1 : 1 + n * (RD_LAT + 1);

    req_wr = wr; req_addr = addr; req_len = len; req_wdata = wdata; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 64) begin @(negedge bus2ip_clk); w++; end
    check("req_ready_idle", 256'(req_ready), 256'(1));
    @(posedge bus2ip_clk);
    @(negedge bus2ip_clk);
    req_valid = 1'b0;

    for (int t = 1; t < trsp; t++) begin
      exp_rdce = 0; exp_wrce = 0; exp_a = '0; exp_d = '0;
      if (wr) begin
        if (t <= n) begin
          exp_wrce = 1; beat = t - 1;
          exp_a = base + 32'(4*beat);
          exp_d = wdata[32*beat +: 32];
        end
      end else if ((t - 1) % (RD_LAT + 1) == 0) begin
        exp_rdce = 1; beat = (t - 1) / (RD_LAT + 1);
        exp_a = base + 32'(4*beat);
      end
      check("bus_beat", {rd_ce, wr_ce, bus_addr, bus_data}, {exp_rdce, exp_wrce, exp_a, exp_d});
      check("busy_phase", {rsp_valid, req_ready, busy}, 3'b001);
      if (t == abort_t) begin
        bus2ip_rst_n = 1'b0;
        #1;
        check("async_reset", {req_ready, rsp_valid, rsp_rdata, bus_addr, bus_data, rd_ce, wr_ce, busy},
              {1'b1, 1'b0, 128'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        @(negedge bus2ip_clk);
        @(negedge bus2ip_clk);
        bus2ip_rst_n = 1'b1;
        @(negedge bus2ip_clk);
        check("post_reset_idle", {req_ready, rsp_valid, busy}, 3'b100);
        return;
      end
      @(negedge bus2ip_clk);
    end

    for (int h = 0; h < hold; h++) begin
      if (queue_req) begin
        req_valid = 1'b1; req_wr = 1'b1; req_addr = $urandom; req_len = 2'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      check("hold_bus_idle", {rd_ce, wr_ce, bus_addr, bus_data}, 66'h0);
      check("hold_state", {rsp_valid, req_ready, busy}, 3'b101);
      check("hold_rdata", rsp_rdata, exp_rd);
      @(negedge bus2ip_clk);
    end
    rsp_ready = 1'b1;
    check("rsp_state", {rsp_valid, req_ready, busy}, 3'b101);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_bus_idle", {rd_ce, wr_ce, bus_addr, bus_data}, 66'h0);
    @(negedge bus2ip_clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("after_rsp", {rsp_valid, req_ready, busy}, 3'b010);
    if (wr) for (int i = 0; i < n; i++) ref_mem[base + 32'(4*i)] = wdata[32*i +: 32];
  endtask

  initial begin
    logic [31:0]  a;
    logic [127:0] wd;
    bus2ip_rst_n = 1'b0;
    repeat (3) @(negedge bus2ip_clk);
    check("reset_values", {req_ready, rsp_valid, rsp_rdata, bus_addr, bus_data, rd_ce, wr_ce, busy},
          {1'b1, 1'b0, 128'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    bus2ip_rst_n = 1'b1;
    @(negedge bus2ip_clk);

    do_txn(1'b1, 32'h10, 2'd0, 128'hDEAD_BEEF, 0, 1'b0, 0);
    do_txn(1'b1, 32'h40, 2'd2, 128'h0000_0033_0000_0022_0000_0011, 1, 1'b0, 0);
    do_txn(1'b0, 32'h40, 2'd2, 128'h0, 0, 1'b0, 0);
    check("burst_read_const", 256'({ref_rd(32'h48), ref_rd(32'h44), ref_rd(32'h40)}),
          256'(96'h0000_0033_0000_0022_0000_0011));
    do_txn(1'b1, 32'h80, 2'd3, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 20, 1'b1, 0);
    do_txn(1'b0, 32'h83, 2'd3, 128'h0, 0, 1'b0, 0);
    do_txn(1'b1, 32'hFFFF_FFFC, 2'd1, 128'h0000_0000_0000_0000_CAFE_0001_CAFE_0000, 0, 1'b0, 0);
    do_txn(1'b0, 32'hFFFF_FFFC, 2'd1, 128'h0, 2, 1'b0, 0);
    do_txn(1'b0, 32'h40, 2'd3, 128'h0, 0, 1'b0, 1 + (RD_LAT + 1));
    do_txn(1'b0, 32'h44, 2'd0, 128'h0, 0, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else                           a = 32'h200 + 32'(4 * $urandom_range(0, 7));
      a  = a | 32'($urandom_range(0, 3));
      wd = {$urandom, $urandom, $urandom, $urandom};
      do_txn(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), wd,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
